// File: rtl/seq_left_shifter.sv
// seq_left_shifter: multi-cycle logical left shifter, STEP bits per clock.
// Optional rotate mode when SEQ_SHIFTER_ROTATE_EN is defined.
module seq_left_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic               rotate,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [SHAMT_W-1:0] STEP_C =
    SHAMT_W'(STEP);

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] k;
  logic [SHAMT_W-1:0] cnt_nx;
  logic [WIDTH-1:0]   shl;
  logic               accept;

`ifdef SEQ_SHIFTER_ROTATE_EN
  logic               rot_q;
  logic [SHAMT_W:0]   rk;
  logic [WIDTH-1:0]   shr;
`endif

  // One step: shift by min(STEP, cnt), wrapping bits in rotate mode.
  always_comb begin
    accept = start & (state != SHIFT);
    k      = (cnt > STEP_C) ? STEP_C : cnt;
    cnt_nx = cnt - k;
    shl    = result << k;
`ifdef SEQ_SHIFTER_ROTATE_EN
    rk     = (SHAMT_W+1)'(WIDTH) - {1'b0, k};
    shr    = result >> rk;
    if (rot_q) shl = shl | shr;
`endif
  end

  // Control FSM with registered busy/done and the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot_q  <= 1'b0;
`endif
    end else if (accept) begin
      result <= a;
      cnt    <= shamt;
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot_q  <= rotate;
`endif
      if (shamt != '0) begin
        state <= SHIFT;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end else begin
      unique case (state)
        SHIFT: begin
          result <= shl;
          cnt    <= cnt_nx;
          if (cnt_nx == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_left_shifter.sv
// tb_seq_left_shifter: scoreboard bench for seq_left_shifter.
// Two instances: STEP=1 (u1) and STEP=4 (u4).
module tb_seq_left_shifter;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic        rot = 1'b0;
  logic [31:0] a = '0;
  logic [4:0]  shamt = '0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seq_left_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rotate(rot),
`endif
    .a(a), .shamt(shamt),
    .busy(busy1), .done(done1), .result(res1)
  );

  seq_left_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rotate(rot),
`endif
    .a(a), .shamt(shamt),
    .busy(busy4), .done(done4), .result(res4)
  );

  // Monitors: pop expected result on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (busy1 && done1) begin
        errors++;
        $display("FAIL excl1 busy=1 done=1 required not both");
      end
      checks++;
      if (busy4 && done4) begin
        errors++;
        $display("FAIL excl4 busy=1 done=1 required not both");
      end
      if (done1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL u1_spurious_done res=%h cyc=%0d",
                   res1, cyc);
        end else begin
          exp_t e;
          e = q1.pop_front();
          if (res1 !== e.res || cyc != e.cyc) begin
            errors++;
            $display("FAIL u1_result got %h @%0d req %h @%0d",
                     res1, cyc, e.res, e.cyc);
          end
        end
      end
      if (done4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL u4_spurious_done res=%h cyc=%0d",
                   res4, cyc);
        end else begin
          exp_t e;
          e = q4.pop_front();
          if (res4 !== e.res || cyc != e.cyc) begin
            errors++;
            $display("FAIL u4_result got %h @%0d req %h @%0d",
                     res4, cyc, e.res, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h req %h", nm, got, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input bit s4, input logic [31:0] av,
                       input logic [4:0] sv, input bit rv,
                       input logic [31:0] ex, input bit push);
    exp_t e;
    int   st;
    st    = s4 ? 4 : 1;
    a     = av;
    shamt = sv;
    rot   = rv;
    e.res = ex;
    e.cyc = cyc + 1 + (int'(sv) + st - 1) / st;
    if (push) begin
      if (s4) q4.push_back(e);
      else q1.push_back(e);
    end
    if (s4) start4 = 1'b1;
    else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0 ||
            busy1 || busy4 || done1 || done4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_timeout q1=%0d q4=%0d req empty",
               nm, q1.size(), q4.size());
      q1.delete();
      q4.delete();
    end
  endtask

  initial begin
    logic [31:0] held;
    repeat (2) @(negedge clk);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_res1", res1, 32'h0);
    chk("rst_res4", res4, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-width shift, STEP=1: 31 busy cycles.
    issue(0, 32'h0000_0001, 5'd31, 0, 32'h8000_0000, 1);
    chk("t1_busy", 32'(busy1), 32'd1);
    drain("t1");
    held = res1;
    repeat (3) @(negedge clk);
    chk("t1_hold", res1, 32'h8000_0000);
    chk("t1_hold2", res1, held);

    // Zero shift: done right after the start edge.
    issue(0, 32'h1234_5678, 5'd0, 0, 32'h1234_5678, 1);
    chk("t2_busy", 32'(busy1), 32'd0);
    chk("t2_done", 32'(done1), 32'd1);
    drain("t2");

    issue(0, 32'hA5A5_A5A5, 5'd8, 0, 32'hA5A5_A500, 1);
    drain("t1b");

    // STEP=4 cases, including a partial final step.
    issue(1, 32'hFFFF_FFFF, 5'd7, 0, 32'hFFFF_FF80, 1);
    drain("t3");
    issue(1, 32'h1234_5678, 5'd16, 0, 32'h5678_0000, 1);
    drain("t3b");
    issue(1, 32'h0000_0001, 5'd31, 0, 32'h8000_0000, 1);
    drain("t3c");
    issue(1, 32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF, 1);
    drain("t3d");

    // Restart mid-SHIFT ignored; then back-to-back in DONE.
    issue(0, 32'h0000_000F, 5'd4, 0, 32'h0000_00F0, 1);
    issue(0, 32'h0000_0001, 5'd1, 0, 32'h0, 0);
    a     = 32'h0;
    shamt = 5'd0;
    begin
      int n;
      n = 0;
      while (!done1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t4_done_seen", 32'(done1), 32'd1);
    end
    issue(0, 32'h0000_0003, 5'd2, 0, 32'h0000_000C, 1);
    chk("t4_b2b_busy", 32'(busy1), 32'd1);
    drain("t4");

    // Reset mid-SHIFT: immediate clear, no done afterwards.
    issue(0, 32'h0000_00FF, 5'd10, 0, 32'h0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy1), 32'd0);
    chk("t5_done", 32'(done1), 32'd0);
    chk("t5_res", res1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("t5_idle_res", res1, 32'h0);

`ifdef SEQ_SHIFTER_ROTATE_EN
    issue(0, 32'h8000_0001, 5'd1, 1, 32'h0000_0003, 1);
    drain("t6r");
    issue(0, 32'h8000_0001, 5'd1, 0, 32'h0000_0002, 1);
    drain("t6l");
    issue(1, 32'h8000_000F, 5'd6, 1, 32'h0000_03E0, 1);
    drain("t6r4");
`endif

    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL pending q1=%0d q4=%0d req 0",
               q1.size(), q4.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
